result_accumulator: RTL and testbench
=====================================

Name: result_accumulator

Overview:
- Downstream stage of the systolic result path. Consumes synchronised partial-sum rows (MATRIX_SIZE lanes × PARTIAL_SUM_BW) produced after the result sync/de-skew controller.
- Accumulates each row across NUM_TILES K-tiles of one output block.
- On completion, requantises each row (shift, activation, saturate to DATA_BW) and streams it back as a WORDSIZE-wide word with a unified-buffer write address.

Parameters:
- MATRIX_SIZE, 8, lanes per row.
- PARTIAL_SUM_BW, 20, input lane width (signed).
- ACC_BW, 24, accumulator lane width (signed); must be ≥ PARTIAL_SUM_BW+4.
- DATA_BW, 8, output lane width (signed).
- ROWS, 8, rows per output block (≥2).
- ADDRESSSIZE, 10, unified-buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- num_tiles  in  4  K-tiles to accumulate, latched at start; 0 is treated as 1.
- shift  in  5  arithmetic right-shift for requant, latched at start.
- base_addr  in  ADDRESSSIZE  write address of output row 0, latched at start.
- in_valid  in  1  input row valid.
- in_ready  out  1  accept input row.
- in_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  signed lanes; lane i = bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_BW*MATRIX_SIZE  requantised lanes, same lane packing.
- out_addr  out  ADDRESSSIZE  base_addr + row index.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at block completion.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; in_ready, out_valid, done, busy = 0; out_data, out_addr = 0; row and tile counters = 0. Accumulator contents are not cleared. Reset mid-block aborts it; no partial output is emitted afterwards.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 → ACCUM; latch num_tiles (0→1), shift and base_addr; row=0, tile=0.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1; a row is accepted on in_valid & in_ready.
  - tile==0: acc[row] = sign-extended in_data. Otherwise acc[row] += sign-extended in_data, lane-wise, wrapping modulo 2^ACC_BW.
  - row increments per accept and wraps ROWS-1→0, incrementing tile.
  - Accept of row ROWS-1 in the last tile → DRAIN; in_ready drops the next cycle.
- DRAIN:
  - On DRAIN entry, the output register loads row 0; out_valid=1 from the first DRAIN cycle (1 cycle after the final accept).
  - out_data/out_addr are held stable while out_valid & !out_ready.
  - On each handshake the register loads the next row in the same edge, so one row per cycle is sustained under out_ready=1.
  - Handshake on row ROWS-1 → DONE; out_valid=0.
- DONE: done=1 for exactly one cycle → IDLE.
- Requant per lane:
  - v = acc >>> shift (arithmetic, truncating).
  - With RESULT_RELU_EN: clamp to [0, 2^(DATA_BW-1)-1].
  - Without RESULT_RELU_EN: clamp to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1].
- out_addr = base_addr + row, modulo 2^ADDRESSSIZE (wraps silently).
- Latency: one block = ROWS*tiles accept cycles + ROWS drain handshakes + 1 done cycle, plus 1 cycle from the final accept to the first out_valid.

Optional Feature:
- Macro RESULT_RELU_EN.
- Defined: ReLU, so negative results output 0; positive results saturate at 127 (DATA_BW=8).
- Undefined: symmetric signed saturation to [-128, 127]; no ReLU.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/ACCUM/DRAIN/DONE);
  - ACC_BW default;
  - a lane sign-extend helper function;
  - the requant/saturate function (shift, clamp, RELU_EN-dependent bounds).
- One sub-module: requant_lane, a combinational, single-lane ACC_BW→DATA_BW requantiser, instantiated MATRIX_SIZE times.
- The accumulator array and FSM remain in result_accumulator.

Test Plan:
- num_tiles=1, shift=0, every lane of row r = r → out rows 0..7 with lanes = r; addr = base_addr+r; done pulses once, one cycle after the row-7 handshake.
- num_tiles=3, shift=2, all lanes = 100 each tile → acc=300 → out lanes 75.
- Saturation, input lane = -5000 then +70000, shift=4: RELU_EN → 0 and 127; no RELU_EN → -128 and 127.
- Backpressure, out_ready toggling 1,0,0,1…: out_data/out_addr hold while stalled; no row lost or duplicated; 8 handshakes total.
- num_tiles=0 behaves as 1. start pulsed during ACCUM is ignored. base_addr=1020 → out_addr wraps 1020..1023, 0..3.
- rst asserted mid-ACCUM (after 5 rows) → next cycle IDLE with all outputs 0; a fresh start plus 8 rows yields correct results unaffected by stale accumulator contents.

Source files
------------

// File: rtl/result_accumulator_pkg.sv
// result_accumulator_pkg: shared types and helpers for the result accumulator.
// Holds the FSM state encoding, default lane widths, the lane sign-extend helper
// and the requantise/saturate function. Macro RESULT_RELU_EN selects ReLU clamping.
package result_accumulator_pkg;

   localparam int RA_PSUM_BW = 20;   // partial-sum lane width
   localparam int RA_ACC_BW  = 24;   // accumulator lane width
   localparam int RA_DATA_BW = 8;    // requantised output lane width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ra_state_t;

   localparam logic signed [RA_ACC_BW-1:0] Q_HI = RA_ACC_BW'((1 << (RA_DATA_BW-1)) - 1);
`ifdef RESULT_RELU_EN
   localparam logic signed [RA_ACC_BW-1:0] Q_LO = '0;
`else
   localparam logic signed [RA_ACC_BW-1:0] Q_LO = RA_ACC_BW'(-(1 << (RA_DATA_BW-1)));
`endif

   function automatic logic [RA_ACC_BW-1:0] sign_ext(input logic [RA_PSUM_BW-1:0] lane);
      sign_ext = {{(RA_ACC_BW-RA_PSUM_BW){lane[RA_PSUM_BW-1]}}, lane};
   endfunction

   // Arithmetic (floor) shift, then clamp into the output range.
   function automatic logic [RA_DATA_BW-1:0] requant(input logic [RA_ACC_BW-1:0] acc,
                                                    input logic [4:0]           sh);
      logic signed [RA_ACC_BW-1:0] v;
      v = $signed(acc) >>> sh;
      if (v > Q_HI)
         requant = Q_HI[RA_DATA_BW-1:0];
      else if (v < Q_LO)
         requant = Q_LO[RA_DATA_BW-1:0];
      else
         requant = v[RA_DATA_BW-1:0];
   endfunction

endpackage

// File: rtl/result_accumulator_requant_lane.sv
// requant_lane: combinational single-lane requantiser, accumulator width to output width.
// Ports: acc_in (signed accumulator lane), shift (right-shift amount), q_out (saturated lane).
// Bounds follow RESULT_RELU_EN through the package requant function.
module requant_lane
   import result_accumulator_pkg::*;
(
   input  logic [RA_ACC_BW-1:0]  acc_in,
   input  logic [4:0]            shift,
   output logic [RA_DATA_BW-1:0] q_out
);

   assign q_out = requant(acc_in, shift);

endmodule

// File: rtl/result_accumulator.sv
// result_accumulator: accumulates partial-sum rows over K-tiles, then streams
// requantised rows with unified-buffer write addresses.
// Ports: start/num_tiles/shift/base_addr configure a block; in_* valid/ready row input;
// out_* valid/ready word output (held while stalled); busy level, done one-cycle pulse.
// Optional macro RESULT_RELU_EN selects ReLU clamping instead of signed saturation.
module result_accumulator
   import result_accumulator_pkg::*;
#(
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = RA_PSUM_BW,
   parameter int ACC_BW         = RA_ACC_BW,
   parameter int DATA_BW        = RA_DATA_BW,
   parameter int ROWS           = 8,
   parameter int ADDRESSSIZE    = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [3:0]                          num_tiles,
   input  logic [4:0]                          shift,
   input  logic [ADDRESSSIZE-1:0]              base_addr,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_BW*MATRIX_SIZE-1:0]      out_data,
   output logic [ADDRESSSIZE-1:0]              out_addr,
   output logic                                busy,
   output logic                                done
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   ra_state_t                       state_q, state_d;
   logic [ROW_W-1:0]                row_q, row_d;
   logic [3:0]                      tile_q, tile_d;
   logic [3:0]                      num_tiles_q, num_tiles_d;
   logic [4:0]                      shift_q, shift_d;
   logic [ADDRESSSIZE-1:0]          base_addr_q, base_addr_d;
   logic                            out_valid_q, out_valid_d;
   logic [DATA_BW*MATRIX_SIZE-1:0]  out_data_q, out_data_d;
   logic [ADDRESSSIZE-1:0]          out_addr_q, out_addr_d;

   logic [ACC_BW-1:0]               acc_q [ROWS][MATRIX_SIZE];
   logic [ACC_BW-1:0]               acc_d [ROWS][MATRIX_SIZE];

   logic                            load_en;
   logic [ROW_W-1:0]                load_row;
   logic [DATA_BW*MATRIX_SIZE-1:0]  rq_data;

   // Requantisers look at the row about to be loaded into the output register.
   for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
      requant_lane u_rq (
         .acc_in (acc_q[load_row][g]),
         .shift  (shift_q),
         .q_out  (rq_data[g*DATA_BW +: DATA_BW])
      );
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      tile_d      = tile_q;
      num_tiles_d = num_tiles_q;
      shift_d     = shift_q;
      base_addr_d = base_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      acc_d       = acc_q;
      load_en     = 1'b0;
      load_row    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ACCUM;
               num_tiles_d = (num_tiles == 4'd0) ? 4'd1 : num_tiles;
               shift_d     = shift;
               base_addr_d = base_addr;
               row_d       = '0;
               tile_d      = '0;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               for (int i = 0; i < MATRIX_SIZE; i++) begin
                  // First tile overwrites, so stale contents never leak into a block.
                  if (tile_q == 4'd0)
                     acc_d[row_q][i] = sign_ext(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]);
                  else
                     acc_d[row_q][i] = acc_q[row_q][i]
                                     + sign_ext(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]);
               end
               if (row_q == ROW_LAST) begin
                  row_d = '0;
                  if (tile_q == num_tiles_q - 4'd1) begin
                     // Row 0 is already final here (only the last row is being written),
                     // so the first output word can load on this same edge.
                     state_d     = ST_DRAIN;
                     load_en     = 1'b1;
                     load_row    = '0;
                     out_valid_d = 1'b1;
                  end else begin
                     tile_d = tile_q + 4'd1;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (row_q == ROW_LAST) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
               end else begin
                  row_d    = row_q + 1'b1;
                  load_en  = 1'b1;
                  load_row = row_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_en) begin
         out_data_d = rq_data;
         out_addr_d = base_addr_q + ADDRESSSIZE'(load_row);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         tile_q      <= '0;
         num_tiles_q <= '0;
         shift_q     <= '0;
         base_addr_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         tile_q      <= tile_d;
         num_tiles_q <= num_tiles_d;
         shift_q     <= shift_d;
         base_addr_q <= base_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
      end
   end

   // Accumulator storage is deliberately not reset.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_result_accumulator.sv
module tb_result_accumulator;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   num_tiles;
   logic [4:0]   shift;
   logic [9:0]   base_addr;
   logic         in_valid;
   logic         in_ready;
   logic [159:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_data;
   logic [9:0]   out_addr;
   logic         busy;
   logic         done;

   int n_err    = 0;
   int n_checks = 0;

   // Expected lane i of output row r = exp_base[r] + i*exp_step (as 8-bit).
   int exp_base [8];
   int exp_step;

   always #5 clk = ~clk;

   result_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_tiles (num_tiles),
      .shift     (shift),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_row(input int v, input int s);
      int cyc;
      for (int i = 0; i < 8; i++) in_data[i*20 +: 20] = 20'(v + i*s);
      in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] t, input logic [4:0] sh, input logic [9:0] b);
      num_tiles = t;
      shift     = sh;
      base_addr = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      chk("start_busy", {63'd0, busy}, 64'd1);
   endtask

   task automatic drain_check(input string tag, input logic [9:0] b, input bit toggle);
      bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int            h, cyc, p;
      logic [63:0]   e;
      logic [9:0]    ea;
      chk({tag, "_first_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_in_ready_low"}, {63'd0, in_ready}, 64'd0);
      h = 0; cyc = 0; p = 0;
      while (h < 8 && cyc < 100) begin
         out_ready = toggle ? pat[p % 4] : 1'b1;
         p++;
         @(negedge clk);
         if (out_valid) begin
            for (int i = 0; i < 8; i++) e[i*8 +: 8] = 8'(exp_base[h] + i*exp_step);
            ea = b + 10'(h);
            chk($sformatf("%s_data_r%0d", tag, h), out_data, e);
            chk($sformatf("%s_addr_r%0d", tag, h), {54'd0, out_addr}, {54'd0, ea});
            if (out_ready) h++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      chk({tag, "_handshakes"}, 64'(h), 64'd8);
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
      chk({tag, "_valid_off"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk({tag, "_done_once"}, {63'd0, done}, 64'd0);
      chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; num_tiles = '0; shift = '0; base_addr = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_addr", {54'd0, out_addr}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Test 1: one tile, shift 0, lane i of row r = r+i; start pulsed mid-block.
      do_start(4'd1, 5'd0, 10'd16);
      for (int r = 0; r < 8; r++) begin
         if (r == 3) begin start = 1'b1; num_tiles = 4'd2; end
         send_row(r, 1);
         start = 1'b0;
         exp_base[r] = r;
      end
      exp_step = 1;
      drain_check("t1", 10'd16, 1'b0);

      // Test 2: three tiles of 100, shift 2 -> 300>>>2 = 75, with backpressure.
      do_start(4'd3, 5'd2, 10'd0);
      for (int t = 0; t < 3; t++)
         for (int r = 0; r < 8; r++) send_row(100, 0);
      for (int r = 0; r < 8; r++) exp_base[r] = 75;
      exp_step = 0;
      drain_check("t2", 10'd0, 1'b1);

      // Test 3: saturation, -5000>>>4 = -313, 70000>>>4 = 4375.
      do_start(4'd1, 5'd4, 10'd100);
      for (int r = 0; r < 8; r++) begin
         send_row((r % 2 == 0) ? -5000 : 70000, 0);
`ifdef RESULT_RELU_EN
         exp_base[r] = (r % 2 == 0) ? 0 : 127;
`else
         exp_base[r] = (r % 2 == 0) ? -128 : 127;
`endif
      end
      exp_step = 0;
      drain_check("t3", 10'd100, 1'b0);

      // Test 4: num_tiles=0 acts as 1; address wraps from 1020.
      do_start(4'd0, 5'd0, 10'd1020);
      for (int r = 0; r < 8; r++) begin
         send_row(r*3 - 10, 0);
         exp_base[r] = r*3 - 10;
      end
      exp_step = 0;
      drain_check("t4", 10'd1020, 1'b0);

      // Test 5: reset after 5 rows of a two-tile block, then a clean block.
      do_start(4'd2, 5'd0, 10'd200);
      for (int r = 0; r < 5; r++) send_row(50, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t5_rst_busy", {63'd0, busy}, 64'd0);
      chk("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("t5_rst_done", {63'd0, done}, 64'd0);
      chk("t5_rst_out_data", out_data, 64'd0);
      chk("t5_rst_out_addr", {54'd0, out_addr}, 64'd0);
      do_start(4'd1, 5'd0, 10'd300);
      for (int r = 0; r < 8; r++) begin
         send_row(-7 + r, 2);
         exp_base[r] = -7 + r;
      end
      exp_step = 2;
      drain_check("t5", 10'd300, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
